freq_meter: RTL and testbench

- Receiving-end counterpart to the clock divider. It takes a slow, divided or external clock-like signal and measures its period and high time in units of the system clock.
- Used to verify divider outputs at runtime and to report them to software-visible status registers.
- The input is asynchronous to the system clock and is synchronised internally.

---
 rtl/freq_meter_pkg.sv | 15 +
 rtl/freq_meter_sync_edge.sv | 43 ++++
 rtl/freq_meter.sv | 133 +++++++++++++
 tb/tb_freq_meter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared state encoding and reset polarity for the frequency meter.
`ifndef RST
`define RST 1'b0
`endif

package freq_meter_pkg;

  // Measurement FSM states; the unused encoding 2'd3 falls back to IDLE.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_MEAS = 2'd2
  } state_t;

endpackage

// File: rtl/freq_meter_sync_edge.sv
// sync_edge: multi-flop synchroniser for an asynchronous level, followed by a
// delay flop that turns level changes into one-cycle rise and fall strobes.
`ifndef RST
`define RST 1'b0
`endif

module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_async,
  output logic d_sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   dly;

  // Shift the asynchronous input through the synchroniser chain.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == `RST) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d_async};
    end
  end

  // Remember the previous synchronised level for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == `RST) begin
      dly <= 1'b0;
    end else begin
      dly <= d_sync;
    end
  end

  assign d_sync = chain[SYNC_STAGES-1];
  assign rise   = d_sync & ~dly;
  assign fall   = ~d_sync & dly;

endmodule

// File: rtl/freq_meter.sv
// freq_meter: measures period and high time of a slow asynchronous clock-like
// input in system clock cycles, with a sticky timeout when edges stop.
`ifndef RST
`define RST 1'b0
`endif

module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT     = 1000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             meas_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             timeout,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hi_cap;
  logic             meas_sync;
  logic             rise;
  logic             fall;
  logic             fall_lvl;
  logic             cnt_expired;

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk    (clk),
    .rst    (rst),
    .d_async(meas_in),
    .d_sync (meas_sync),
    .rise   (rise),
    .fall   (fall)
  );

  assign fall_lvl    = fall & ~meas_sync;
  assign cnt_expired = (cnt == CNT_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == `RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: en low always wins, rise beats timeout.
  always_comb begin
    state_next = state;
    if (!en) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  state_next = S_ARM;
        S_ARM:   if (rise) state_next = S_MEAS;
        S_MEAS:  if (!rise && cnt_expired) state_next = S_ARM;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Status outputs decoded from the state.
  always_comb begin
    busy = (state == S_ARM) || (state == S_MEAS);
  end

  // Counter, high-time capture, result registers and sticky timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == `RST) begin
      cnt       <= '0;
      hi_cap    <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (!en) begin
        cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            cnt     <= '0;
            timeout <= 1'b0;
          end
          S_ARM: begin
            if (rise) begin
              cnt    <= '0;
              hi_cap <= '0;
            end else if (cnt_expired) begin
              cnt     <= '0;
              timeout <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          S_MEAS: begin
            if (rise) begin
              period    <= cnt + CNT_ONE;
              high_time <= hi_cap;
              valid     <= 1'b1;
              cnt       <= '0;
            end else if (cnt_expired) begin
              cnt     <= '0;
              timeout <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
              if (fall_lvl) begin
                hi_cap <= cnt + CNT_ONE;
              end
            end
          end
          default: cnt <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: directed vector bench for freq_meter with an in-bench divider
// generating the measured signal.
module tb_freq_meter;

  localparam int CNT_W       = 32;
  localparam int TIMEOUT     = 20;
  localparam int SYNC_STAGES = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             meas_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             timeout;
  logic             busy;

  int errors = 0;
  int checks = 0;

  int divRatio = 4;
  int divPhase = 0;
  bit divOn    = 1'b0;

  typedef struct {
    int ratio;
    int cycles;
    int skip;
    int expPeriod;
    int expHigh;
  } vec_t;

  vec_t vecs[4];

  // Free-running system clock.
  always #5 clk = ~clk;

  freq_meter #(
    .CNT_W      (CNT_W),
    .TIMEOUT    (TIMEOUT),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .meas_in  (meas_in),
    .period   (period),
    .high_time(high_time),
    .valid    (valid),
    .timeout  (timeout),
    .busy     (busy)
  );

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkAtLeast(input string name, input int actual, input int required);
    checks++;
    if (actual < required) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, required at least %0d", name, actual, required);
    end
  endtask

  // One system clock: wait for the falling edge, then advance the divider.
  task automatic tick();
    @(negedge clk);
    if (divOn) begin
      meas_in  = (divPhase < divRatio / 2);
      divPhase = (divPhase + 1 == divRatio) ? 0 : divPhase + 1;
    end
  endtask

  // Run the divider at one ratio and check every settled valid pulse.
  task automatic applyStimulus(input vec_t v, input bit restartPhase, input string tag);
    int vcount  = 0;
    int lastIdx = -1;
    divRatio = v.ratio;
    if (restartPhase) divPhase = 0;
    divOn = 1'b1;
    for (int c = 0; c < v.cycles; c++) begin
      tick();
      if (valid) begin
        if (vcount >= v.skip) begin
          checkOutput({tag, ".period"}, period, v.expPeriod);
          checkOutput({tag, ".high"}, high_time, v.expHigh);
          if (vcount > 0) checkOutput({tag, ".interval"}, c - lastIdx, v.expPeriod);
        end
        lastIdx = c;
        vcount++;
      end
    end
    checkAtLeast({tag, ".valids"}, vcount - v.skip, (v.cycles - 8) / v.ratio - v.skip);
  endtask

  // Bound the whole run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 100000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int nValid;
    vec_t v;
    rst     = 1'b0;
    en      = 1'b0;
    meas_in = 1'b0;
    vecs[0] = '{ratio: 4,  cycles: 40, skip: 0, expPeriod: 4,  expHigh: 2};
    vecs[1] = '{ratio: 10, cycles: 60, skip: 2, expPeriod: 10, expHigh: 5};
    vecs[2] = '{ratio: 6,  cycles: 48, skip: 2, expPeriod: 6,  expHigh: 3};
    vecs[3] = '{ratio: 2,  cycles: 40, skip: 2, expPeriod: 2,  expHigh: 1};

    repeat (2) tick();
    checkOutput("reset.period", period, 0);
    checkOutput("reset.high", high_time, 0);
    checkOutput("reset.valid", valid, 0);
    checkOutput("reset.timeout", timeout, 0);
    checkOutput("reset.busy", busy, 0);

    rst = 1'b1;
    en  = 1'b1;
    repeat (3) tick();
    checkOutput("arm.busy", busy, 1);
    checkOutput("arm.valid", valid, 0);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i], 1'b1, $sformatf("vec%0d", i));
    end
    checkOutput("vecs.timeout", timeout, 0);

    // Input stops while measuring: timeout, back to ARM, no valid.
    divOn   = 1'b0;
    meas_in = 1'b0;
    repeat (5) tick();
    nValid = 0;
    repeat (30) begin
      tick();
      if (valid) nValid++;
    end
    checkOutput("measTimeout.noValid", nValid, 0);
    checkOutput("measTimeout.flag", timeout, 1);
    checkOutput("measTimeout.busy", busy, 1);

    // en toggle clears timeout, then ARM times out again after TIMEOUT cycles.
    en = 1'b0;
    repeat (3) tick();
    checkOutput("idle.busy", busy, 0);
    checkOutput("idle.timeoutHeld", timeout, 1);
    en     = 1'b1;
    nValid = 0;
    repeat (2) tick();
    checkOutput("armEntry.timeout", timeout, 0);
    checkOutput("armEntry.busy", busy, 1);
    repeat (8) begin
      tick();
      if (valid) nValid++;
    end
    checkOutput("armWait.timeout", timeout, 0);
    repeat (15) begin
      tick();
      if (valid) nValid++;
    end
    checkOutput("armTimeout.flag", timeout, 1);
    checkOutput("armTimeout.noValid", nValid, 0);

    // Measurements resume while timeout stays sticky.
    v = '{ratio: 4, cycles: 40, skip: 1, expPeriod: 4, expHigh: 2};
    applyStimulus(v, 1'b1, "resume4");
    checkOutput("resume4.timeoutSticky", timeout, 1);

    // en drop mid-period with divide-by-8.
    v = '{ratio: 8, cycles: 48, skip: 2, expPeriod: 8, expHigh: 4};
    applyStimulus(v, 1'b1, "div8");
    repeat (3) tick();
    en     = 1'b0;
    nValid = 0;
    repeat (3) begin
      tick();
      if (valid) nValid++;
      checkOutput("drop.busy", busy, 0);
    end
    checkOutput("drop.noValid", nValid, 0);
    checkOutput("drop.periodHeld", period, 8);
    checkOutput("drop.timeoutHeld", timeout, 1);
    en = 1'b1;
    repeat (2) tick();
    checkOutput("rearm.timeoutCleared", timeout, 0);
    v = '{ratio: 8, cycles: 48, skip: 0, expPeriod: 8, expHigh: 4};
    applyStimulus(v, 1'b0, "rearm8");

    // Asynchronous reset between clock edges.
    tick();
    #2;
    rst = 1'b0;
    #1;
    checkOutput("asyncRst.period", period, 0);
    checkOutput("asyncRst.high", high_time, 0);
    checkOutput("asyncRst.valid", valid, 0);
    checkOutput("asyncRst.timeout", timeout, 0);
    checkOutput("asyncRst.busy", busy, 0);
    repeat (2) tick();
    rst = 1'b1;
    v = '{ratio: 8, cycles: 48, skip: 1, expPeriod: 8, expHigh: 4};
    applyStimulus(v, 1'b0, "afterReset");
    checkOutput("afterReset.timeout", timeout, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
